// File: rtl/alu_pkg.sv
// Shared definitions for the 7-bit NOR/ROR ALU and its issue controller.
package alu_pkg;

  localparam int unsigned DATA_W = 7;

  localparam logic OP_NOR = 1'b0;
  localparam logic OP_ROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_e;

endpackage

// File: rtl/alu_nor_ror.sv
// 7-bit combinational ALU: NOR of both operands, or rotate-right of A by B[2:0].
module alu_nor_ror
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] result,
  output logic              cf,
  output logic              sf,
  output logic              zf
);

  always_comb begin
    if (op == OP_ROR) begin
      // Rotate amount 7 wraps to the identity in a 7-bit word.
      result = DATA_W'({a, a} >> b[2:0]);
    end else begin
      result = ~(a | b);
    end
    cf = 1'b0;
    sf = result[DATA_W-1];
    zf = (result == '0);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front-end for the NOR/ROR ALU: registers operands, captures the result
// and flags, and delivers them downstream with backpressure and a delivery count.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_op,
  input  logic              in_chain,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cf,
  input  logic              alu_sf,
  input  logic              alu_zf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_cf,
  output logic              out_sf,
  output logic              out_zf,
  output logic [CNT_W-1:0]  op_count,
  input  logic              clr_count
);

  state_e            state_q;
  logic [DATA_W-1:0] last_result_q;
  logic              last_valid_q;
  logic              out_xfer;

  assign in_ready = (state_q == IDLE);
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_cf        <= 1'b0;
      out_sf        <= 1'b0;
      out_zf        <= 1'b0;
      last_result_q <= '0;
      last_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            alu_a   <= (in_chain && last_valid_q) ? last_result_q : in_a;
            alu_b   <= in_b;
            alu_op  <= in_op;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // ALU output has had a full cycle to settle from the operand registers.
          out_result    <= alu_result;
          out_cf        <= alu_cf;
          out_sf        <= alu_sf;
          out_zf        <= alu_zf;
          last_result_q <= alu_result;
          last_valid_q  <= 1'b1;
          out_valid     <= 1'b1;
          state_q       <= HOLD;
        end
        HOLD: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (clr_count) begin
      op_count <= '0;
    end else if (out_xfer && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl driving the NOR/ROR ALU with a 2-bit counter.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              cf;
    logic              sf;
    logic              zf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_op, in_chain;
  logic [DATA_W-1:0] in_a, in_b;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic              alu_op, alu_cf, alu_sf, alu_zf;
  logic              out_valid, out_ready, out_cf, out_sf, out_zf, clr_count;
  logic [DATA_W-1:0] out_result;
  logic [CNT_W-1:0]  op_count;

  int                n_checks = 0;
  int                n_fails  = 0;
  exp_t              sb_q[$];
  exp_t              got;
  int                exp_count = 0;
  logic [DATA_W-1:0] m_last_result = '0;
  logic              m_last_valid  = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_chain   (in_chain),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cf     (alu_cf),
    .alu_sf     (alu_sf),
    .alu_zf     (alu_zf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cf     (out_cf),
    .out_sf     (out_sf),
    .out_zf     (out_zf),
    .op_count   (op_count),
    .clr_count  (clr_count)
  );

  alu_nor_ror u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .cf     (alu_cf),
    .sf     (alu_sf),
    .zf     (alu_zf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t alu_ref(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic op);
    exp_t              e;
    logic [DATA_W-1:0] r;
    if (op) begin
      r = a;
      for (int i = 0; i < int'(b[2:0]); i++) r = {r[0], r[DATA_W-1:1]};
    end else begin
      r = ~(a | b);
    end
    e.result = r;
    e.cf     = 1'b0;
    e.sf     = r[DATA_W-1];
    e.zf     = (r == 0);
    return e;
  endfunction

  // Scoreboard: pop on every downstream transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        got = sb_q.pop_front();
        check_eq("sb_result", 32'(out_result), 32'(got.result));
        check_eq("sb_cf", 32'(out_cf), 32'(got.cf));
        check_eq("sb_sf", 32'(out_sf), 32'(got.sf));
        check_eq("sb_zf", 32'(out_zf), 32'(got.zf));
      end
    end
  end

  // Runs accept, issue and stall phases; if deliver is set, completes the transfer.
  task automatic do_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic op, input logic chain, input int stall,
                       input logic clr, input logic deliver);
    logic [DATA_W-1:0] ea;
    exp_t              e;
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    ea = (chain && m_last_valid) ? m_last_result : a;
    e  = alu_ref(ea, b, op);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_chain = chain;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = DATA_W'($urandom); in_b = DATA_W'($urandom);
    in_op = 1'($urandom); in_chain = 1'($urandom);
    sb_q.push_back(e);
    m_last_result = e.result;
    m_last_valid  = 1'b1;
    check_eq("alu_a", 32'(alu_a), 32'(ea));
    check_eq("alu_b", 32'(alu_b), 32'(b));
    check_eq("alu_op", 32'(alu_op), 32'(op));
    check_eq("out_valid_issue", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("out_valid_t2", 32'(out_valid), 32'd1);
    check_eq("in_ready_hold", 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_result", 32'(out_result), 32'(e.result));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_count", 32'(op_count), 32'(exp_count));
    end
    if (deliver) begin
      out_ready = 1'b1; clr_count = clr;
      @(posedge clk); #1;
      out_ready = 1'b0; clr_count = 1'b0;
      if (clr) exp_count = 0;
      else if (exp_count < (1 << CNT_W) - 1) exp_count++;
      check_eq("out_valid_done", 32'(out_valid), 32'd0);
      check_eq("in_ready_done", 32'(in_ready), 32'd1);
      check_eq("op_count", 32'(op_count), 32'(exp_count));
      check_eq("alu_a_held", 32'(alu_a), 32'(ea));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_chain = 1'b0;
    out_ready = 1'b0; clr_count = 1'b0;
    #3;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_alu_a", 32'(alu_a), 32'd0);
    check_eq("rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_out_result", 32'(out_result), 32'd0);
    check_eq("rst_flags", 32'({out_cf, out_sf, out_zf}), 32'd0);
    check_eq("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    // Traffic during reset must not be accepted.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("rst_no_accept", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(7'h0F, 7'h30, OP_NOR, 1'b0, 0, 1'b0, 1'b1);  // 0x40, SF
    do_op(7'h01, 7'h03, OP_ROR, 1'b0, 0, 1'b0, 1'b1);  // 0x10
    do_op(7'h7F, 7'h00, OP_NOR, 1'b0, 0, 1'b0, 1'b1);  // 0x00, ZF
    do_op(7'h01, 7'h01, OP_ROR, 1'b0, 0, 1'b0, 1'b1);  // 0x40, count saturates
    do_op(7'h55, 7'h00, OP_NOR, 1'b1, 0, 1'b0, 1'b1);  // chained -> 0x3F
    do_op(7'h2A, 7'h07, OP_ROR, 1'b0, 5, 1'b0, 1'b1);  // backpressure, rotate by 7
    do_op(7'h33, 7'h4C, OP_NOR, 1'b0, 1, 1'b1, 1'b1);  // clear wins over transfer
    do_op(7'h00, 7'h00, OP_NOR, 1'b1, 0, 1'b0, 1'b1);  // chain 0x00 -> 0x7F

    // Reset while holding a result: dropped, counter and chain state cleared.
    do_op(7'h11, 7'h22, OP_NOR, 1'b0, 2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_hold_valid", 32'(out_valid), 32'd0);
    check_eq("rst_hold_count", 32'(op_count), 32'd0);
    check_eq("rst_hold_in_ready", 32'(in_ready), 32'd1);
    void'(sb_q.pop_back());
    exp_count = 0;
    m_last_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(7'h12, 7'h05, OP_NOR, 1'b1, 0, 1'b0, 1'b1);  // chain after reset -> in_a

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
